// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and the note-event record
// passed from the message parser to the voice allocator.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPR     = 4'hD;
  localparam logic [3:0] SYS      = 4'hF;

  // P_SYSEX behaves as IDLE except that data bytes are swallowed silently.
  typedef enum logic [2:0] {
    P_IDLE,
    P_SYSEX,
    P_D1,
    P_D2,
    P_SKIP1,
    P_SKIP2A,
    P_SKIP2B
  } parse_state_e;

  typedef struct packed {
    logic       is_on;
    logic [6:0] note;
    logic [6:0] vel;
  } midi_event_t;

  function automatic logic is_realtime(input logic [7:0] b);
    return b[7:3] == 5'b11111;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status. Emits a combinational
// one-cycle note event on the byte_valid carrying the final data byte.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int MIDI_CHAN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        evt_valid,
  output midi_event_t evt,
  output logic        stray
);

  localparam logic [3:0] CHAN = 4'(MIDI_CHAN);

  parse_state_e state_reg, state_next;
  logic         on_reg, on_next;
  logic [6:0]   note_reg, note_next;
  logic [3:0]   nibble;

  assign nibble = byte_in[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= P_IDLE;
      on_reg    <= 1'b0;
      note_reg  <= '0;
    end else begin
      state_reg <= state_next;
      on_reg    <= on_next;
      note_reg  <= note_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    on_next    = on_reg;
    note_next  = note_reg;
    evt_valid  = 1'b0;
    evt        = '0;
    stray      = 1'b0;
    if (byte_valid) begin
      if (byte_in[7]) begin
        // Real-time bytes are transparent; any other status aborts a partial message.
        if (!is_realtime(byte_in)) begin
          if (nibble == SYS) begin
            state_next = P_SYSEX;
          end else if ((nibble == NOTE_ON || nibble == NOTE_OFF) && byte_in[3:0] == CHAN) begin
            state_next = P_D1;
            on_next    = (nibble == NOTE_ON);
          end else if (nibble == PROG || nibble == CHPR) begin
            state_next = P_SKIP1;
          end else begin
            state_next = P_SKIP2A;
          end
        end
      end else begin
        case (state_reg)
          P_IDLE:   stray = 1'b1;
          P_SYSEX:  ;
          P_D1: begin
            note_next  = byte_in[6:0];
            state_next = P_D2;
          end
          P_D2: begin
            evt_valid  = 1'b1;
            evt.is_on  = on_reg && (byte_in[6:0] != 7'd0);
            evt.note   = note_reg;
            evt.vel    = byte_in[6:0];
            state_next = P_D1;
          end
          P_SKIP1:  ;
          P_SKIP2A: state_next = P_SKIP2B;
          P_SKIP2B: state_next = P_SKIP2A;
          default:  state_next = P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/midi_poly_voice_ctrl.sv
// Polyphonic MIDI front end: parses note messages and allocates them across
// NUM_VOICES voices. Define VOICE_STEAL_EN to steal the oldest voice when full.
module midi_poly_voice_ctrl
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int MIDI_CHAN  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    all_off,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    drop_pulse
);

  localparam int AGE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int IDX_W = AGE_W;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  logic        evt_valid;
  midi_event_t evt;
  logic        stray;

  midi_msg_parser #(.MIDI_CHAN(MIDI_CHAN)) u_parser (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .evt_valid  (evt_valid),
    .evt        (evt),
    .stray      (stray)
  );

  logic [6:0]       note_reg   [NUM_VOICES];
  logic [6:0]       note_next  [NUM_VOICES];
  logic [6:0]       vel_reg    [NUM_VOICES];
  logic [6:0]       vel_next   [NUM_VOICES];
  logic [AGE_W-1:0] age_reg    [NUM_VOICES];
  logic [AGE_W-1:0] age_next   [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_reg, active_next;
  logic [NUM_VOICES-1:0] trig_reg, trig_next;
  logic                  drop_reg, drop_next;

  logic [NUM_VOICES-1:0] hit_mask;
  logic [NUM_VOICES-1:0] free_mask;
  logic [IDX_W-1:0]      hit_idx, free_idx, tgt_idx;
  logic                  do_alloc;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign hit_mask[gi]          = active_reg[gi] && (note_reg[gi] == evt.note);
    assign free_mask[gi]         = !active_reg[gi];
    assign voice_note[7*gi +: 7] = note_reg[gi];
    assign voice_vel[7*gi +: 7]  = vel_reg[gi];
  end

  assign voice_active = active_reg;
  assign voice_trig   = trig_reg;
  assign drop_pulse   = drop_reg;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (hit_mask[i])  hit_idx  = IDX_W'(i);
      if (free_mask[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;

  // Strict compare keeps the lowest index among equally old voices.
  always_comb begin
    old_idx = '0;
    old_age = age_reg[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_reg[i] > old_age) begin
        old_idx = IDX_W'(i);
        old_age = age_reg[i];
      end
    end
  end
`endif

  always_comb begin
    note_next   = note_reg;
    vel_next    = vel_reg;
    age_next    = age_reg;
    active_next = active_reg;
    trig_next   = '0;
    drop_next   = stray;
    do_alloc    = 1'b0;
    tgt_idx     = '0;
    if (all_off) begin
      active_next = '0;
      for (int i = 0; i < NUM_VOICES; i++) age_next[i] = '0;
    end else if (evt_valid) begin
      if (evt.is_on) begin
        do_alloc = 1'b1;
        if (|hit_mask) begin
          tgt_idx = hit_idx;
        end else if (|free_mask) begin
          tgt_idx = free_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          tgt_idx = old_idx;
`else
          do_alloc  = 1'b0;
          drop_next = 1'b1;
`endif
        end
        if (do_alloc) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == tgt_idx) begin
              note_next[i]   = evt.note;
              vel_next[i]    = evt.vel;
              active_next[i] = 1'b1;
              age_next[i]    = '0;
              trig_next[i]   = 1'b1;
            end else if (active_reg[i] && age_reg[i] != AGE_MAX) begin
              age_next[i] = age_reg[i] + 1'b1;
            end
          end
        end
      end else begin
        // Note/velocity are kept so the wave generator can run its release.
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (hit_mask[i]) active_next[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_reg[i] <= '0;
        vel_reg[i]  <= '0;
        age_reg[i]  <= '0;
      end
      active_reg <= '0;
      trig_reg   <= '0;
      drop_reg   <= 1'b0;
    end else begin
      note_reg   <= note_next;
      vel_reg    <= vel_next;
      age_reg    <= age_next;
      active_reg <= active_next;
      trig_reg   <= trig_next;
      drop_reg   <= drop_next;
    end
  end

endmodule
